// File: rtl/bcd_countdown_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and helpers for the BCD countdown controller:
//   state_t      - controller phases
//   key_t        - the single winning key of a cycle after priority resolution
//   bcd_time_t   - packed minutes:seconds pair, two BCD digits per field
//   pick_key     - Clear > Pause > Start > Load priority encoder
//   clamp_preset - forces a raw preset into a legal BCD MM:SS value
//   bcd_dec      - one-second decrement with BCD digit borrows
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  typedef enum logic [2:0] {KEY_NONE, KEY_LOAD, KEY_START, KEY_PAUSE, KEY_CLEAR} key_t;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [3:0] DIGIT_MAX = 4'h9;

  function automatic key_t pick_key(input logic load, input logic start,
                                    input logic pause, input logic clear);
    if (clear)      return KEY_CLEAR;
    else if (pause) return KEY_PAUSE;
    else if (start) return KEY_START;
    else if (load)  return KEY_LOAD;
    else            return KEY_NONE;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

  // A seconds tens digit above 5 cannot be repaired digit-wise, so the whole
  // field saturates to 59.
  function automatic bcd_time_t clamp_preset(input logic [7:0] set_min,
                                             input logic [7:0] set_sec);
    bcd_time_t r;
    r.min = {clamp_digit(set_min[7:4]), clamp_digit(set_min[3:0])};
    r.sec = (set_sec[7:4] > 4'd5) ? SEC_MAX
                                  : {set_sec[7:4], clamp_digit(set_sec[3:0])};
    return r;
  endfunction

  // Caller guarantees t != 00:00, so the minutes borrow never underflows.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec[3:0] != 4'd0) begin
      r.sec[3:0] = t.sec[3:0] - 4'd1;
    end else if (t.sec[7:4] != 4'd0) begin
      r.sec = {t.sec[7:4] - 4'd1, DIGIT_MAX};
    end else begin
      r.sec = SEC_MAX;
      if (t.min[3:0] != 4'd0) r.min[3:0] = t.min[3:0] - 4'd1;
      else                    r.min      = {t.min[7:4] - 4'd1, DIGIT_MAX};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_countdown_ctrl_if
// Key pulses and presets toward the controller, display/buzzer state back.
//   master : keypad/test side  (drives Load, SetMin, SetSec, Start, Pause, Clear)
//   slave  : the controller    (drives Min, Sec, Running, Alarm, Tick)
// -----------------------------------------------------------------------------
interface bcd_countdown_ctrl_if;

  logic       Load;
  logic [7:0] SetMin;
  logic [7:0] SetSec;
  logic       Start;
  logic       Pause;
  logic       Clear;
  logic [7:0] Min;
  logic [7:0] Sec;
  logic       Running;
  logic       Alarm;
  logic       Tick;

  modport master (
    output Load, SetMin, SetSec, Start, Pause, Clear,
    input  Min, Sec, Running, Alarm, Tick
  );

  modport slave (
    input  Load, SetMin, SetSec, Start, Pause, Clear,
    output Min, Sec, Running, Alarm, Tick
  );

endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Gated divide-by-CLK_HZ counter producing the 1 Hz step strobe.
//   Clk  in  system clock
//   Rst  in  asynchronous active-low reset
//   En   in  count enable; the count holds its value while low
//   Clr  in  synchronous clear, dominant over En
//   Tick out high for the cycle in which the count sits at CLK_HZ-1 while En
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int CLK_HZ = 1000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int             W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0]   TC = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)          cnt <= '0;
    else if (Clr)      cnt <= '0;
    else if (En)       cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
  end

  assign Tick = En && (cnt == TC);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_countdown_ctrl
// Countdown-timer controller: IDLE / RUN / PAUSE / ALARM sequencing of a BCD
// MM:SS register driven by a gated 1 Hz prescaler and single-cycle keys.
//   Clk  in  system clock (CLK_HZ)
//   Rst  in  asynchronous active-low reset
//   bus  slave modport: Load/SetMin/SetSec/Start/Pause/Clear in,
//        Min/Sec/Running/Alarm/Tick out (all outputs registered)
// Parameters: CLK_HZ (cycles per second), ALARM_SEC (alarm length in ticks).
// -----------------------------------------------------------------------------
module bcd_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ    = 1000,
  parameter int ALARM_SEC = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  bcd_countdown_ctrl_if.slave  bus
);

  localparam int            AW         = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  state_t         state_q, state_d;
  bcd_time_t      time_q, time_d, dec_time;
  logic [AW-1:0]  acnt_q, acnt_d;
  key_t           key;
  logic           pre_en, pre_clr, pre_tick;
  logic           tick_q, running_q, alarm_q;

  assign key      = pick_key(bus.Load, bus.Start, bus.Pause, bus.Clear);
  assign dec_time = bcd_dec(time_q);

  // A Pause or Clear edge freezes the prescaler, so a step falling on that
  // edge is deferred (Pause) or dropped (Clear). ALARM ignores Pause.
  assign pre_en = ((state_q == RUN) && (key != KEY_PAUSE) && (key != KEY_CLEAR)) ||
                  (state_q == ALARM);

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .Clk  (Clk),
    .Rst  (Rst),
    .En   (pre_en),
    .Clr  (pre_clr),
    .Tick (pre_tick)
  );

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    acnt_d  = acnt_q;
    pre_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        case (key)
          KEY_CLEAR: time_d = '0;
          KEY_START: begin
            if (time_q != '0) begin
              state_d = RUN;
              pre_clr = 1'b1;
            end
          end
          KEY_LOAD:  time_d = clamp_preset(bus.SetMin, bus.SetSec);
          default:   ;
        endcase
      end

      RUN: begin
        case (key)
          KEY_CLEAR: begin
            state_d = IDLE;
            time_d  = '0;
            pre_clr = 1'b1;
          end
          KEY_PAUSE: state_d = PAUSE;
          default: begin
            if (pre_tick) begin
              time_d = dec_time;
              if (dec_time == '0) begin
                state_d = ALARM;
                acnt_d  = '0;
                pre_clr = 1'b1;
              end
            end
          end
        endcase
      end

      PAUSE: begin
        case (key)
          KEY_CLEAR: begin
            state_d = IDLE;
            time_d  = '0;
            pre_clr = 1'b1;
          end
          KEY_START: state_d = RUN;
          default:   ;
        endcase
      end

      ALARM: begin
        if ((key == KEY_CLEAR) || (key == KEY_START)) begin
          state_d = IDLE;
          time_d  = '0;
          pre_clr = 1'b1;
        end else if (pre_tick) begin
          if (acnt_q == ALARM_LAST) begin
            state_d = IDLE;
            pre_clr = 1'b1;
          end else begin
            acnt_d = acnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Tick is only reported for steps that leave the controller in RUN or
  // ALARM; the final alarm tick returns to IDLE silently.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      time_q    <= '0;
      acnt_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      acnt_q    <= acnt_d;
      tick_q    <= pre_tick && ((state_d == RUN) || (state_d == ALARM));
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == ALARM);
    end
  end

  assign bus.Min     = time_q.min;
  assign bus.Sec     = time_q.sec;
  assign bus.Running = running_q;
  assign bus.Alarm   = alarm_q;
  assign bus.Tick    = tick_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_countdown_ctrl
// Self-checking bench for bcd_countdown_ctrl with CLK_HZ=4, ALARM_SEC=5.
// The reference model tracks remaining time as a plain count of seconds and
// the elapsed cycles within the current second/alarm; display values are
// derived from it by decimal arithmetic. Directed scenarios add literal
// expectations, then randomized key traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_bcd_countdown_ctrl;

  localparam int HZ   = 4;
  localparam int ASEC = 5;

  logic clk;
  logic rst_n;

  bcd_countdown_ctrl_if bus();

  bcd_countdown_ctrl #(.CLK_HZ(HZ), .ALARM_SEC(ASEC)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 run, 2 pause, 3 alarm
  int m_phase = 0;
  int m_secs  = 0;
  int m_sub   = 0;
  int m_acyc  = 0;
  bit m_tick  = 0;

  function automatic int preset_secs(input logic [7:0] sm, input logic [7:0] ss);
    int mt, mo, st, so;
    mt = (sm[7:4] > 9) ? 9 : int'(sm[7:4]);
    mo = (sm[3:0] > 9) ? 9 : int'(sm[3:0]);
    st = int'(ss[7:4]);
    so = (ss[3:0] > 9) ? 9 : int'(ss[3:0]);
    if (st > 5) return (mt * 10 + mo) * 60 + 59;
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_secs = 0; m_sub = 0; m_acyc = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      case (m_phase)
        0: begin
          if (bus.Clear)      m_secs = 0;
          else if (bus.Pause) ;
          else if (bus.Start) begin
            if (m_secs > 0) begin m_phase = 1; m_sub = 0; end
          end
          else if (bus.Load)  m_secs = preset_secs(bus.SetMin, bus.SetSec);
        end
        1: begin
          if (bus.Clear)      begin m_phase = 0; m_secs = 0; end
          else if (bus.Pause) m_phase = 2;
          else begin
            m_sub++;
            if (m_sub == HZ) begin
              m_sub = 0;
              m_secs--;
              m_tick = 1;
              if (m_secs == 0) begin m_phase = 3; m_acyc = 0; end
            end
          end
        end
        2: begin
          if (bus.Clear)      begin m_phase = 0; m_secs = 0; end
          else if (bus.Pause) ;
          else if (bus.Start) m_phase = 1;
        end
        default: begin
          if (bus.Clear || (bus.Start && !bus.Pause)) m_phase = 0;
          else begin
            m_acyc++;
            if (m_acyc == ASEC * HZ)  m_phase = 0;
            else if (m_acyc % HZ == 0) m_tick = 1;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("min",     bus.Min,     to_bcd(m_secs / 60));
    check("sec",     bus.Sec,     to_bcd(m_secs % 60));
    check("running", bus.Running, (m_phase == 1));
    check("alarm",   bus.Alarm,   (m_phase == 3));
    check("tick",    bus.Tick,    m_tick);
  end

  // ---------------- stimulus helpers ----------------
  task automatic go(input logic ld, input logic st, input logic pa, input logic cl,
                    input logic [7:0] sm = 8'h00, input logic [7:0] ss = 8'h00);
    bus.Load = ld; bus.Start = st; bus.Pause = pa; bus.Clear = cl;
    bus.SetMin = sm; bus.SetSec = ss;
    @(posedge clk); #1;
    bus.Load = 1'b0; bus.Start = 1'b0; bus.Pause = 1'b0; bus.Clear = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Load = 1'b0; bus.Start = 1'b0; bus.Pause = 1'b0; bus.Clear = 1'b0;
    bus.SetMin = 8'h00; bus.SetSec = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_min",   bus.Min,     16'h00);
    check("rst_run",   bus.Running, 16'h0);
    rst_n = 1'b1;
    wait_cycles(1);

    // Reset mid-run
    go(1, 0, 0, 0, 8'h00, 8'h05);
    go(0, 1, 0, 0);
    wait_cycles(8);
    check("mid_sec",   bus.Sec,     16'h03);
    check("mid_run",   bus.Running, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sec",  bus.Sec,     16'h00);
    check("arst_run",  bus.Running, 16'h0);
    check("arst_tick", bus.Tick,    16'h0);
    check("arst_alm",  bus.Alarm,   16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    go(0, 1, 0, 0);
    wait_cycles(5);
    check("zero_start_run", bus.Running, 16'h0);

    // Full countdown 01:02
    go(1, 0, 0, 0, 8'h01, 8'h02);
    go(0, 1, 0, 0);
    wait_cycles(3);
    check("fc_k3_sec",  bus.Sec,  16'h02);
    wait_cycles(1);
    check("fc_k4_sec",  bus.Sec,  16'h01);
    check("fc_k4_tick", bus.Tick, 16'h1);
    wait_cycles(4);
    check("fc_k8_sec",  bus.Sec,  16'h00);
    wait_cycles(4);
    check("fc_k12_min", bus.Min,  16'h00);
    check("fc_k12_sec", bus.Sec,  16'h59);
    wait_cycles(235);
    check("fc_k247_sec", bus.Sec,   16'h01);
    check("fc_k247_alm", bus.Alarm, 16'h0);
    wait_cycles(1);
    check("fc_k248_alm", bus.Alarm,   16'h1);
    check("fc_k248_sec", bus.Sec,     16'h00);
    check("fc_k248_run", bus.Running, 16'h0);
    wait_cycles(19);
    check("fc_alm_hold", bus.Alarm, 16'h1);
    wait_cycles(1);
    check("fc_alm_end",  bus.Alarm, 16'h0);
    check("fc_end_tick", bus.Tick,  16'h0);

    // Pause / resume 00:03
    go(1, 0, 0, 0, 8'h00, 8'h03);
    go(0, 1, 0, 0);
    wait_cycles(6);
    go(0, 0, 1, 0);
    check("pz_sec", bus.Sec,     16'h02);
    check("pz_run", bus.Running, 16'h0);
    for (int i = 0; i < 100; i++) begin
      wait_cycles(1);
      check("pz_hold_tick", bus.Tick, 16'h0);
    end
    check("pz_hold_sec", bus.Sec, 16'h02);
    go(0, 1, 0, 0);
    wait_cycles(1);
    check("rs_r1_sec",  bus.Sec,  16'h02);
    wait_cycles(1);
    check("rs_r2_sec",  bus.Sec,  16'h01);
    check("rs_r2_tick", bus.Tick, 16'h1);
    go(0, 0, 0, 1);

    // Clamp
    go(1, 0, 0, 0, 8'hA7, 8'h7C);
    check("clamp_min", bus.Min, 16'h97);
    check("clamp_sec", bus.Sec, 16'h59);
    go(1, 0, 0, 0, 8'h3F, 8'h4B);
    check("clamp2_min", bus.Min, 16'h39);
    check("clamp2_sec", bus.Sec, 16'h49);
    go(0, 0, 0, 1);

    // Priority collision on a terminal-count edge
    go(1, 0, 0, 0, 8'h00, 8'h09);
    go(0, 1, 0, 0);
    wait_cycles(3);
    go(0, 1, 1, 1);
    check("col_run",  bus.Running, 16'h0);
    check("col_sec",  bus.Sec,     16'h00);
    check("col_tick", bus.Tick,    16'h0);

    // Alarm silence
    go(1, 0, 0, 0, 8'h00, 8'h01);
    go(0, 1, 0, 0);
    wait_cycles(4);
    check("sil_alm_on", bus.Alarm, 16'h1);
    go(0, 1, 0, 0);
    check("sil_alm_off", bus.Alarm,   16'h0);
    check("sil_run",     bus.Running, 16'h0);

    // Randomized single-key traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [7:0] sm, ss;
      r  = $urandom_range(0, 99);
      sm = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      ss = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 9))};
      if (r < 3)       go(1, 0, 0, 0, sm, ss);
      else if (r < 7)  go(0, 1, 0, 0);
      else if (r < 9)  go(0, 0, 1, 0);
      else if (r < 10) go(0, 0, 0, 1);
      else             go(0, 0, 0, 0);
    end

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_ctrl.md
# bcd_countdown_ctrl

Countdown-timer controller for the 1 kHz board clock domain. It owns a gated 1 Hz prescaler and sequences a two-field BCD minutes:seconds register through load, run, pause and alarm phases under single-cycle key pulses. Outputs drive the seven-segment display mux and the buzzer driver directly.

## Interface
Parameters:
- CLK_HZ, 1000, input clock frequency; one tick every CLK_HZ cycles (bench overrides to 4)
- ALARM_SEC, 5, alarm duration in ticks

Ports:
- Clk  in  1  system clock (1 kHz)
- Rst  in  1  reset, asynchronous, active-low
- Load  in  1  one-cycle pulse, capture SetMin/SetSec (IDLE only)
- SetMin  in  8  preset minutes, BCD 00-99
- SetSec  in  8  preset seconds, BCD 00-59
- Start  in  1  one-cycle pulse, start/resume; also silences alarm
- Pause  in  1  one-cycle pulse, pause a running count
- Clear  in  1  one-cycle pulse, abort to IDLE and zero the time
- Min  out  8  current minutes, BCD
- Sec  out  8  current seconds, BCD
- Running  out  1  high in RUN
- Alarm  out  1  high in ALARM
- Tick  out  1  one-cycle pulse, registered, marks each applied 1 Hz step

## Operation
- Reset (Rst=0, async): state IDLE, Min=Sec=8'h00, Running=0, Alarm=0, Tick=0, prescaler=0.
- Key priority when several pulse in one cycle: Clear > Pause > Start > Load.
- IDLE: Load captures presets; any BCD digit >9 clamps to 9, Sec tens >5 clamps Sec to 8'h59. Start with Min:Sec = 00:00 ignored; otherwise prescaler cleared, -> RUN. Pause ignored.
- RUN: prescaler counts; on its terminal count (CLK_HZ-1) it wraps to 0 and time decrements by one second. Borrow: ones 0 -> 9 with tens decrement; Sec 00 -> 59 with Min decrement (01:00 -> 00:59, 10:00 -> 09:59). Decrement reaching 00:00 -> ALARM on that same edge. Pause -> PAUSE. Clear -> IDLE, time zeroed. Load ignored.
- PAUSE: prescaler and time frozen (value held, not cleared). Start -> RUN, resumes mid-second. Clear -> IDLE, time zeroed. Load, Pause ignored.
- ALARM: Min:Sec stays 00:00; prescaler cleared on entry and keeps running; after ALARM_SEC ticks -> IDLE. Start or Clear -> IDLE immediately. Load, Pause ignored.
- Tick asserts in RUN and ALARM only, never in IDLE/PAUSE.

## Timing
- All state, counters and outputs registered on posedge Clk; no combinational input-to-output path.
- Start accepted at edge k: first decrement at edge k+CLK_HZ; Tick high during the cycle after that edge, coincident with the new Min/Sec value.
- Preset M:S reaches ALARM exactly (60M+S)*CLK_HZ cycles after the accepting Start edge, excluding paused cycles.
- Running/Alarm change on the same edge as the state change.
- Pause on the same edge as a terminal count: Pause wins, no decrement, prescaler holds CLK_HZ-1; the step applies on the first cycle after resume.
- Clear on a terminal-count edge: IDLE, 00:00, no Tick.
- Alarm duration: ALARM_SEC*CLK_HZ cycles, Alarm falls on the edge of the final tick.
- Rst deassertion mid-RUN behaves as a fresh reset; no state retained.

## Structure
- Package timer_pkg: state enum (IDLE, RUN, PAUSE, ALARM), BCD constants SEC_MAX=8'h59, DIGIT_MAX=4'h9, a BCD decrement-with-borrow function and a preset clamp function.
- Sub-module tick_prescaler: ports Clk, Rst, En, Clr, Tick; counter width $clog2(CLK_HZ); pulses on terminal count while En, holds while !En, Clr synchronous and dominant.
- Top holds FSM, BCD registers, alarm tick counter, output registers.

## Test plan
- Reset mid-run: CLK_HZ=4, Load 00:05, Start, assert Rst after 9 cycles -> all outputs 0 asynchronously, state IDLE, Start with 00:00 then ignored.
- Full countdown: Load 01:02, Start -> Sec 01, 00, then Min:Sec 00:59; 00:00 and Alarm=1 after 62*4=248 cycles; Alarm clears after 5*4=20 more cycles.
- Pause/resume: Load 00:03, Start, Pause after 6 cycles (Sec=02) -> held 100 cycles, no Tick; Start -> Sec 01 after exactly 2 more cycles.
- Clamp: Load SetMin=8'hA7, SetSec=8'h7C -> Min=8'h97, Sec=8'h59.
- Priority collision: in RUN pulse Clear, Pause, Start together on a terminal-count edge -> IDLE, 00:00, Tick stays 0.
- Alarm silence: Load 00:01, Start, Start pulse during ALARM -> Alarm falls next edge, IDLE, Running=0.
